change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Output stage directly downstream of the vending controller FSM.
- Consumes the controller's registered vend strobe and 3-bit change code, and turns them into physical actuator timing:
  - a product-motor pulse;
  - a train of 5-unit coin ejections from the return hopper, each confirmed by the hopper exit sensor.
- Reports completion, coins paid and hopper faults to the front panel logic.

Parameters:
MOTOR_CYCLES, 8, cycles motor_on is held high per vend (>=1)
EJECT_HIGH, 4, cycles eject is held high per coin (>=1)
EJECT_GAP, 4, idle cycles between coin ejections (>=1)
SENSE_TIMEOUT, 16, max cycles after eject falls to wait for coin_sensed (>=1)
CNT_W, 5, width of the internal timer; must hold max(MOTOR_CYCLES, EJECT_HIGH, EJECT_GAP, SENSE_TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vend_in  in  1  vend request from controller (level; held across cycles possible)
change_in  in  3  change code: 000=0, 001=5, 010=10, 011=15, 100=20 units; 101-111 illegal
coin_sensed  in  1  hopper exit sensor, one-cycle pulse per coin dropped
fault_clr  in  1  clears fault and returns FSM to IDLE
motor_on  out  1  product motor drive
eject  out  1  hopper solenoid drive
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of each transaction
coins_paid  out  3  coins confirmed by coin_sensed in current/last transaction
drop  out  1  one-cycle pulse: request lost because pending slot full
fault  out  1  sticky hopper fault

Behaviour:
- All outputs are registered. Reset drives every output to 0, FSM to IDLE, pending slot empty, and the previous-sample register to 0.
- Request event:
  - req = {vend_in, change_in}, sampled every cycle.
  - An event occurs when req != 0 and req differs from the previous cycle's sample. Holding a constant nonzero req is one event only.
- Illegal code (change_in >= 101) in an event:
  - event ignored; fault=1; FSM enters FAULT at the next edge, unless it is already in FAULT.
- Event acceptance:
  - In IDLE: latched as the active job. FSM leaves IDLE at the same edge; busy=1 from the next cycle.
  - Busy, pending slot empty: stored in pending.
  - Busy, pending slot full: drop=1 for one cycle; request discarded.
- Job start: coins_paid cleared to 0. Coin count N = change code value (0..4).
- States:
  - IDLE: waits for an accepted event.
  - MOTOR: only entered if the vend bit is set; otherwise go directly to EJ_HIGH (N>0) or DONE (N=0). motor_on=1 for exactly MOTOR_CYCLES cycles. Next: EJ_HIGH if N>0, else DONE.
  - EJ_HIGH: eject=1 for exactly EJECT_HIGH cycles. Then EJ_WAIT.
  - EJ_WAIT: eject=0; timer counts from 1.
    - coin_sensed=1 -> coins_paid+1 and remaining-1. Next: EJ_GAP if coins remain, else DONE.
    - Timer reaches SENSE_TIMEOUT without coin_sensed -> fault=1, go to FAULT.
  - EJ_GAP: EJECT_GAP idle cycles, then EJ_HIGH.
  - DONE: done=1 for one cycle. Next: load pending (same start rules as IDLE acceptance) if present, else IDLE.
  - FAULT: motor_on=0, eject=0, busy=1. Pending slot is flushed on entry. New events while in FAULT pulse drop. fault_clr=1 -> fault=0 and IDLE at the next edge. coins_paid holds its value.
- coin_sensed outside EJ_WAIT is ignored (no count, no fault).
- motor_on and eject are never high in the same cycle.
- fault_clr outside FAULT has no effect.
- rst mid-job: actuators drop at the next edge; job and pending are lost; no done pulse.
- An event arriving in the same cycle as DONE goes to the pending slot if the slot is empty, else drop.

Test Plan:
- vend_in=1, change_in=000 for 1 cycle, with defaults -> motor_on high for exactly 8 cycles, eject never high, done pulse on the following cycle, coins_paid=0, busy low afterwards.
- vend_in=1, change_in=100 held for 5 cycles; coin_sensed pulsed 2 cycles after each eject falls -> motor 8 cycles, then 4 eject pulses of 4 cycles each with 4-cycle gaps, coins_paid=4, a single done pulse (held input is not re-triggered).
- change_in=010 with no coin_sensed after the first eject -> fault=1 exactly 16 cycles after eject falls, eject stays 0, coins_paid=0, busy=1. fault_clr pulse -> fault=0, IDLE next cycle.
- Three distinct events during one long job (vend+011, then 001, then 010) -> second event held in pending and run after the first job's done pulse; third event produces a drop pulse; two done pulses total.
- change_in=110 in IDLE -> fault=1, FAULT state, no actuator activity. rst asserted during EJ_HIGH of a 3-coin job -> eject=0 and all outputs 0 at the next edge, no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Turns vend/change requests into product-motor and coin-hopper
//            actuator timing, with one pending slot and hopper-fault handling.
// Revision : 1.0
// ============================================================================
module change_dispenser #(
    parameter int MOTOR_CYCLES  = 8,
    parameter int EJECT_HIGH    = 4,
    parameter int EJECT_GAP     = 4,
    parameter int SENSE_TIMEOUT = 16,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_in,
    input  logic [2:0] change_in,
    input  logic       coin_sensed,
    input  logic       fault_clr,
    output logic       motor_on,
    output logic       eject,
    output logic       busy,
    output logic       done,
    output logic [2:0] coins_paid,
    output logic       drop,
    output logic       fault
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_MOTOR   = 3'd1;
    localparam logic [2:0] c_ST_EJ_HIGH = 3'd2;
    localparam logic [2:0] c_ST_EJ_WAIT = 3'd3;
    localparam logic [2:0] c_ST_EJ_GAP  = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;
    localparam logic [2:0] c_ST_FAULT   = 3'd6;

    localparam logic [CNT_W-1:0] c_TMR_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MOTOR_LAST   = CNT_W'(MOTOR_CYCLES);
    localparam logic [CNT_W-1:0] c_EJ_HIGH_LAST = CNT_W'(EJECT_HIGH);
    localparam logic [CNT_W-1:0] c_GAP_LAST     = CNT_W'(EJECT_GAP);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(SENSE_TIMEOUT);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_tmr;
    logic [2:0]       r_remain;
    logic [2:0]       r_coins;
    logic [3:0]       r_prev;
    logic             r_pend_vld;
    logic [3:0]       r_pend;
    logic             r_motor_on;
    logic             r_eject;
    logic             r_busy;
    logic             r_done;
    logic             r_drop;
    logic             r_fault;

    logic [3:0]       w_req;
    logic             w_event;
    logic             w_illegal;
    logic             w_legal;
    logic             w_in_job;
    logic             w_start;
    logic [3:0]       w_start_req;
    logic [2:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_tmr;
    logic [2:0]       w_nxt_remain;
    logic [2:0]       w_nxt_coins;
    logic             w_nxt_pend_vld;
    logic [3:0]       w_nxt_pend;
    logic             w_nxt_drop;
    logic             w_nxt_fault;

    // A constant nonzero request is a single event; only changes re-trigger.
    assign w_req     = {vend_in, change_in};
    assign w_event   = (w_req != 4'd0) && (w_req != r_prev);
    assign w_illegal = w_event && (change_in > 3'd4);
    assign w_legal   = w_event && !w_illegal;
    assign w_in_job  = (r_state == c_ST_MOTOR)   || (r_state == c_ST_EJ_HIGH) ||
                       (r_state == c_ST_EJ_WAIT) || (r_state == c_ST_EJ_GAP);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_tmr      = r_tmr + c_TMR_ONE;
        w_nxt_remain   = r_remain;
        w_nxt_coins    = r_coins;
        w_nxt_pend_vld = r_pend_vld;
        w_nxt_pend     = r_pend;
        w_nxt_drop     = 1'b0;
        w_nxt_fault    = r_fault;
        w_start        = 1'b0;
        w_start_req    = w_req;

        if (w_legal && w_in_job) begin
            if (r_pend_vld) begin
                w_nxt_drop = 1'b1;
            end else begin
                w_nxt_pend_vld = 1'b1;
                w_nxt_pend     = w_req;
            end
        end

        case (r_state)
            c_ST_IDLE: begin
                w_nxt_tmr = r_tmr;
                if (w_legal) begin
                    w_start = 1'b1;
                end
            end
            c_ST_MOTOR: begin
                if (r_tmr == c_MOTOR_LAST) begin
                    w_nxt_tmr   = c_TMR_ONE;
                    w_nxt_state = (r_remain != 3'd0) ? c_ST_EJ_HIGH : c_ST_DONE;
                end
            end
            c_ST_EJ_HIGH: begin
                if (r_tmr == c_EJ_HIGH_LAST) begin
                    w_nxt_tmr   = c_TMR_ONE;
                    w_nxt_state = c_ST_EJ_WAIT;
                end
            end
            c_ST_EJ_WAIT: begin
                // A coin seen on the final timeout cycle still counts.
                if (coin_sensed) begin
                    w_nxt_coins  = r_coins + 3'd1;
                    w_nxt_remain = r_remain - 3'd1;
                    w_nxt_tmr    = c_TMR_ONE;
                    w_nxt_state  = (r_remain > 3'd1) ? c_ST_EJ_GAP : c_ST_DONE;
                end else if (r_tmr == c_TIMEOUT_LAST) begin
                    w_nxt_state    = c_ST_FAULT;
                    w_nxt_fault    = 1'b1;
                    w_nxt_pend_vld = 1'b0;
                end
            end
            c_ST_EJ_GAP: begin
                if (r_tmr == c_GAP_LAST) begin
                    w_nxt_tmr   = c_TMR_ONE;
                    w_nxt_state = c_ST_EJ_HIGH;
                end
            end
            c_ST_DONE: begin
                if (r_pend_vld) begin
                    w_start        = 1'b1;
                    w_start_req    = r_pend;
                    w_nxt_pend_vld = 1'b0;
                    w_nxt_drop     = w_legal;
                end else if (w_legal) begin
                    w_start = 1'b1;
                end else begin
                    w_nxt_state = c_ST_IDLE;
                end
            end
            c_ST_FAULT: begin
                w_nxt_tmr      = r_tmr;
                w_nxt_pend_vld = 1'b0;
                w_nxt_drop     = w_legal;
                if (fault_clr) begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_fault = 1'b0;
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_nxt_coins  = 3'd0;
            w_nxt_remain = w_start_req[2:0];
            w_nxt_tmr    = c_TMR_ONE;
            if (w_start_req[3]) begin
                w_nxt_state = c_ST_MOTOR;
            end else if (w_start_req[2:0] != 3'd0) begin
                w_nxt_state = c_ST_EJ_HIGH;
            end else begin
                w_nxt_state = c_ST_DONE;
            end
        end

        if (w_illegal) begin
            w_nxt_fault    = 1'b1;
            w_nxt_pend_vld = 1'b0;
            w_nxt_coins    = r_coins;
            w_nxt_state    = c_ST_FAULT;
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up cycle-for-cycle with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_tmr      <= '0;
            r_remain   <= 3'd0;
            r_coins    <= 3'd0;
            r_prev     <= 4'd0;
            r_pend_vld <= 1'b0;
            r_pend     <= 4'd0;
            r_motor_on <= 1'b0;
            r_eject    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_tmr      <= w_nxt_tmr;
            r_remain   <= w_nxt_remain;
            r_coins    <= w_nxt_coins;
            r_prev     <= w_req;
            r_pend_vld <= w_nxt_pend_vld;
            r_pend     <= w_nxt_pend;
            r_motor_on <= (w_nxt_state == c_ST_MOTOR);
            r_eject    <= (w_nxt_state == c_ST_EJ_HIGH);
            r_busy     <= (w_nxt_state != c_ST_IDLE);
            r_done     <= (w_nxt_state == c_ST_DONE);
            r_drop     <= w_nxt_drop;
            r_fault    <= w_nxt_fault;
        end
    end

    assign motor_on   = r_motor_on;
    assign eject      = r_eject;
    assign busy       = r_busy;
    assign done       = r_done;
    assign coins_paid = r_coins;
    assign drop       = r_drop;
    assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench: vector table, corner sequences, random jobs.
// Revision : 1.0
// ============================================================================
module tb_change_dispenser;

    localparam int MOTOR_CYCLES  = 8;
    localparam int EJECT_HIGH    = 4;
    localparam int EJECT_GAP     = 4;
    localparam int SENSE_TIMEOUT = 16;
    localparam int NO_FAIL       = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_in;
    logic [2:0] change_in;
    logic       coin_sensed;
    logic       fault_clr;
    logic       motor_on;
    logic       eject;
    logic       busy;
    logic       done;
    logic [2:0] coins_paid;
    logic       drop;
    logic       fault;

    always #5 clk = ~clk;

    change_dispenser #(
        .MOTOR_CYCLES  (MOTOR_CYCLES),
        .EJECT_HIGH    (EJECT_HIGH),
        .EJECT_GAP     (EJECT_GAP),
        .SENSE_TIMEOUT (SENSE_TIMEOUT),
        .CNT_W         (5)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .vend_in     (vend_in),
        .change_in   (change_in),
        .coin_sensed (coin_sensed),
        .fault_clr   (fault_clr),
        .motor_on    (motor_on),
        .eject       (eject),
        .busy        (busy),
        .done        (done),
        .coins_paid  (coins_paid),
        .drop        (drop),
        .fault       (fault)
    );

    typedef struct {
        logic       v;
        logic [2:0] code;
        int         d;       // sensor delay in cycles after eject falls (1..16)
        int         f;       // index of the coin that never arrives, NO_FAIL if none
        int         hold;    // cycles the request is held
        int         e_motor;
        int         e_pulses;
        int         e_coins;
        int         e_done;
        int         e_fault;
    } vec_t;

    int tests = 0;
    int fails = 0;

    int cyc = 0, motor_cyc = 0, ej_hi = 0, ej_rise = 0, done_cnt = 0, drop_cnt = 0;
    int overlap = 0, t_fall = 0, t_fault = 0, gap_last = 0;
    logic mon_ej_d = 1'b0, mon_flt_d = 1'b0;

    int rsp_delay = 2;
    int rsp_fail_abs = 1000;
    int n_falls = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (motor_on) motor_cyc++;
        if (eject) ej_hi++;
        if (eject && !mon_ej_d) begin
            ej_rise++;
            gap_last = cyc - t_fall;
        end
        if (!eject && mon_ej_d) t_fall = cyc;
        if (fault && !mon_flt_d) t_fault = cyc;
        if (done) done_cnt++;
        if (drop) drop_cnt++;
        if (motor_on && eject) overlap++;
        mon_ej_d  = eject;
        mon_flt_d = fault;
    end

    // Hopper model: each coin appears rsp_delay cycles into the sensing window.
    initial begin
        int   pend;
        logic prev_ej;
        pend = 0;
        prev_ej = 1'b0;
        coin_sensed = 1'b0;
        forever begin
            @(negedge clk);
            coin_sensed = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) coin_sensed = 1'b1;
            end
            if (prev_ej && !eject) begin
                if (n_falls != rsp_fail_abs) begin
                    if (rsp_delay <= 1) coin_sensed = 1'b1;
                    else pend = rsp_delay - 1;
                end
                n_falls++;
            end
            prev_ej = eject;
        end
    end

    task automatic run_check(input vec_t t, input string tag);
        int s_motor, s_hi, s_rise, s_done, cnt;
        rsp_delay    = t.d;
        rsp_fail_abs = n_falls + t.f;
        s_motor = motor_cyc; s_hi = ej_hi; s_rise = ej_rise; s_done = done_cnt;
        vend_in   = t.v;
        change_in = t.code;
        repeat (t.hold) @(negedge clk);
        vend_in   = 1'b0;
        change_in = 3'd0;
        cnt = 0;
        while (busy && !fault && cnt < 800) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_finish_in_time"}, int'(cnt < 800), 1);
        repeat (2) @(negedge clk);
        chk({tag, "_motor_cycles"}, motor_cyc - s_motor, t.e_motor);
        chk({tag, "_eject_pulses"}, ej_rise - s_rise, t.e_pulses);
        chk({tag, "_eject_cycles"}, ej_hi - s_hi, t.e_pulses * EJECT_HIGH);
        chk({tag, "_coins_paid"}, int'(coins_paid), t.e_coins);
        chk({tag, "_done_pulses"}, done_cnt - s_done, t.e_done);
        chk({tag, "_fault"}, int'(fault), t.e_fault);
        chk({tag, "_overlap"}, overlap, 0);
        if (t.e_fault != 0) begin
            chk({tag, "_fault_latency"}, t_fault - t_fall, SENSE_TIMEOUT);
            chk({tag, "_fault_busy_eject"}, int'({busy, eject, motor_on}), 4);
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
            chk({tag, "_clr_fault_busy"}, int'({fault, busy}), 0);
        end else begin
            chk({tag, "_busy_after"}, int'(busy), 0);
            if (t.e_pulses >= 2) chk({tag, "_gap"}, gap_last, t.d + EJECT_GAP);
        end
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int   s_done, s_drop, s_rise, s_motor, cnt;

        vecs[0] = '{1'b1, 3'd0, 2,  NO_FAIL, 1, 8, 0, 0, 1, 0};
        vecs[1] = '{1'b1, 3'd4, 2,  NO_FAIL, 5, 8, 4, 4, 1, 0};
        vecs[2] = '{1'b0, 3'd2, 3,  0,       1, 0, 1, 0, 0, 1};
        vecs[3] = '{1'b0, 3'd1, 1,  NO_FAIL, 1, 0, 1, 1, 1, 0};
        vecs[4] = '{1'b1, 3'd3, 16, NO_FAIL, 1, 8, 3, 3, 1, 0};
        vecs[5] = '{1'b1, 3'd4, 5,  2,       1, 8, 3, 2, 0, 1};
        vecs[6] = '{1'b0, 3'd4, 16, NO_FAIL, 2, 0, 4, 4, 1, 0};
        vecs[7] = '{1'b1, 3'd2, 1,  1,       1, 8, 2, 1, 0, 1};

        rst = 1'b1; vend_in = 1'b0; change_in = 3'd0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({motor_on, eject, busy, done, coins_paid, drop, fault}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_check(vecs[i], $sformatf("vec%0d", i));

        // Three distinct events during one job: second pends, third drops.
        rsp_delay = 2; rsp_fail_abs = n_falls + 100;
        s_done = done_cnt; s_drop = drop_cnt; s_rise = ej_rise; s_motor = motor_cyc;
        vend_in = 1'b1; change_in = 3'd3; @(negedge clk);
        vend_in = 1'b0; change_in = 3'd0; repeat (2) @(negedge clk);
        change_in = 3'd1; @(negedge clk);
        change_in = 3'd0; repeat (2) @(negedge clk);
        change_in = 3'd2; @(negedge clk);
        change_in = 3'd0;
        cnt = 0;
        while ((done_cnt - s_done < 2 || busy) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        chk("pend_done_pulses", done_cnt - s_done, 2);
        chk("pend_drop_pulses", drop_cnt - s_drop, 1);
        chk("pend_eject_pulses", ej_rise - s_rise, 4);
        chk("pend_motor_cycles", motor_cyc - s_motor, MOTOR_CYCLES);
        chk("pend_coins_paid", int'(coins_paid), 1);

        // Illegal change code while idle.
        s_rise = ej_rise;
        change_in = 3'd6; @(negedge clk);
        change_in = 3'd0;
        chk("illegal_fault_busy", int'({fault, busy}), 3);
        repeat (5) @(negedge clk);
        chk("illegal_no_actuators", int'({motor_on, eject}) + (ej_rise - s_rise), 0);
        fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        chk("illegal_clr", int'({fault, busy}), 0);

        // Reset in the middle of ejecting a 3-coin job.
        rsp_delay = 2; rsp_fail_abs = n_falls + 100;
        change_in = 3'd3; @(negedge clk);
        change_in = 3'd0;
        cnt = 0;
        while (!eject && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_reached_eject", int'(eject), 1);
        s_done = done_cnt;
        rst = 1'b1; @(negedge clk);
        chk("rst_mid_job_outputs", int'({motor_on, eject, busy, done, coins_paid, drop, fault}), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_no_done", done_cnt - s_done, 0);
        chk("rst_idle", int'(busy), 0);

        // Random jobs; expectations come from job arithmetic, not cycle timing.
        for (int i = 0; i < 40; i++) begin
            rv.v    = 1'($urandom_range(0, 1));
            rv.code = 3'($urandom_range(0, 4));
            if (!rv.v && rv.code == 3'd0) rv.code = 3'd1;
            rv.d    = int'($urandom_range(1, SENSE_TIMEOUT));
            rv.f    = NO_FAIL;
            if (rv.code != 3'd0 && $urandom_range(0, 3) == 0)
                rv.f = int'($urandom_range(0, int'(rv.code) - 1));
            rv.hold    = int'($urandom_range(1, 3));
            rv.e_motor = rv.v ? MOTOR_CYCLES : 0;
            if (rv.f < int'(rv.code)) begin
                rv.e_pulses = rv.f + 1; rv.e_coins = rv.f; rv.e_done = 0; rv.e_fault = 1;
            end else begin
                rv.e_pulses = int'(rv.code); rv.e_coins = int'(rv.code);
                rv.e_done = 1; rv.e_fault = 0;
            end
            run_check(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
